// File: rtl/cvxif_vec_issue_queue_if.sv
// CV-X-IF issue / vector-unit / result bundle for the vector issue queue.
interface cvxif_vec_issue_queue_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_RS  = 2,
  parameter int unsigned ID_W    = 3,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 8
);
  localparam int unsigned RS_W  = NUM_RS * XLEN;
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

  // issue side
  logic              issue_valid_i;
  logic              issue_ready_o;
  logic [31:0]       issue_instr_i;
  logic [ID_W-1:0]   issue_id_i;
  logic [RS_W-1:0]   issue_rs_i;
  logic [NUM_RS-1:0] issue_rs_valid_i;
  logic              issue_accept_o;
  logic              issue_writeback_o;
  logic              flush_i;
  // dispatch side
  logic              vec_valid_o;
  logic              vec_ready_i;
  logic [31:0]       vec_instr_o;
  logic [ID_W-1:0]   vec_id_o;
  logic [RS_W-1:0]   vec_rs_o;
  // completion side
  logic              vec_done_i;
  logic [ID_W-1:0]   vec_done_id_i;
  logic              vec_done_we_i;
  logic [XLEN-1:0]   vec_done_data_i;
  // result side
  logic              result_valid_o;
  logic [ID_W-1:0]   result_id_o;
  logic              result_we_o;
  logic [XLEN-1:0]   result_data_o;
  // status
  logic [OCC_W-1:0]  occupancy_o;
  logic [OUT_W-1:0]  outstanding_o;

  // queue side
  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i, flush_i,
    input  vec_ready_i, vec_done_i, vec_done_id_i, vec_done_we_i, vec_done_data_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o,
    output vec_valid_o, vec_instr_o, vec_id_o, vec_rs_o,
    output result_valid_o, result_id_o, result_we_o, result_data_o,
    output occupancy_o, outstanding_o
  );

  // core / vector-unit side
  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i, flush_i,
    output vec_ready_i, vec_done_i, vec_done_id_i, vec_done_we_i, vec_done_data_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o,
    input  vec_valid_o, vec_instr_o, vec_id_o, vec_rs_o,
    input  result_valid_o, result_id_o, result_we_o, result_data_o,
    input  occupancy_o, outstanding_o
  );
endinterface

// File: rtl/cvxif_vec_issue_queue.sv
// CV-X-IF front end: decodes OP-V issues, buffers them in a FIFO toward the
// vector unit, tracks outstanding instructions and forwards completions.
module cvxif_vec_issue_queue #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_RS  = 2,
  parameter int unsigned ID_W    = 3,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  cvxif_vec_issue_queue_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned AW    = PTR_W + 1;
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned SUM_W = OUT_W + 1;
  localparam int unsigned RS_W  = NUM_RS * XLEN;

  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OCC_W-1:0] occ_q, occ_d, occ_after_pop_c;
  logic [OUT_W-1:0] out_q, out_d;
  logic [SUM_W-1:0] add_c, sub_c;

  logic [31:0]      instr_mem_q [DEPTH];
  logic [ID_W-1:0]  id_mem_q    [DEPTH];
  logic [RS_W-1:0]  rs_mem_q    [DEPTH];

  logic             res_valid_q;
  logic [ID_W-1:0]  res_id_q;
  logic             res_we_q;
  logic [XLEN-1:0]  res_data_q;

  logic is_vec_c, is_wb_c, full_c, empty_c, ready_c, push_c, pop_c;

  // Decode and handshake qualification; full is taken from registered pointers
  // so a same-cycle pop never frees a slot for a push.
  always_comb begin
    is_vec_c = (bus.issue_instr_i[6:0] == 7'b1010111);
    is_wb_c  = is_vec_c && (bus.issue_instr_i[14:12] == 3'b111);
    empty_c  = (wptr_q == rptr_q);
    full_c   = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
               (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    ready_c  = 1'b0;
    if (bus.issue_valid_i && !bus.flush_i) begin
      if (is_vec_c) ready_c = !full_c && (out_q < OUT_W'(MAX_OUT)) && (&bus.issue_rs_valid_i);
      else          ready_c = 1'b1;
    end
    push_c = ready_c && is_vec_c;
    pop_c  = !empty_c && bus.vec_ready_i;
  end

  // Next-state for pointers, occupancy and outstanding count.
  always_comb begin
    wptr_d          = wptr_q;
    rptr_d          = rptr_q;
    occ_after_pop_c = occ_q - OCC_W'(pop_c);
    occ_d           = occ_after_pop_c + OCC_W'(push_c);
    if (push_c) wptr_d = wptr_q + AW'(1);
    if (pop_c)  rptr_d = rptr_q + AW'(1);
    if (bus.flush_i) begin
      // ready is low during flush, so wptr_q is also the post-cycle write pointer
      rptr_d = wptr_q;
      occ_d  = '0;
    end
    add_c = SUM_W'(out_q) + SUM_W'(push_c);
    sub_c = SUM_W'(bus.vec_done_i) + (bus.flush_i ? SUM_W'(occ_after_pop_c) : '0);
    out_d = (add_c >= sub_c) ? OUT_W'(add_c - sub_c) : '0;
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      out_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      out_q  <= out_d;
    end
  end

  // FIFO storage; cleared on reset so head fields read zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem_q[PTR_W'(i)] <= '0;
        id_mem_q[PTR_W'(i)]    <= '0;
        rs_mem_q[PTR_W'(i)]    <= '0;
      end
    end else if (push_c) begin
      instr_mem_q[wptr_q[PTR_W-1:0]] <= bus.issue_instr_i;
      id_mem_q[wptr_q[PTR_W-1:0]]    <= bus.issue_id_i;
      rs_mem_q[wptr_q[PTR_W-1:0]]    <= bus.issue_rs_i;
    end
  end

  // Completion-to-result pass-through, one cycle late, never stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_we_q    <= 1'b0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= bus.vec_done_i;
      if (bus.vec_done_i) begin
        res_id_q   <= bus.vec_done_id_i;
        res_we_q   <= bus.vec_done_we_i;
        res_data_q <= bus.vec_done_data_i;
      end
    end
  end

  // A completion with nothing outstanding indicates a vector-unit protocol error.
  a_done_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus.vec_done_i && (out_q == '0)));

  assign bus.issue_ready_o     = ready_c;
  assign bus.issue_accept_o    = ready_c && is_vec_c;
  assign bus.issue_writeback_o = ready_c && is_wb_c;
  assign bus.vec_valid_o       = !empty_c;
  assign bus.vec_instr_o       = instr_mem_q[rptr_q[PTR_W-1:0]];
  assign bus.vec_id_o          = id_mem_q[rptr_q[PTR_W-1:0]];
  assign bus.vec_rs_o          = rs_mem_q[rptr_q[PTR_W-1:0]];
  assign bus.result_valid_o    = res_valid_q;
  assign bus.result_id_o       = res_id_q;
  assign bus.result_we_o       = res_we_q;
  assign bus.result_data_o     = res_data_q;
  assign bus.occupancy_o       = occ_q;
  assign bus.outstanding_o     = out_q;
endmodule

// File: tb/tb_cvxif_vec_issue_queue.sv
// Directed bench for cvxif_vec_issue_queue: one default instance (MAX_OUT=8)
// and one with MAX_OUT=4 for the outstanding-limit scenario.
module tb_cvxif_vec_issue_queue;
  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  localparam logic [31:0] VSET  = 32'h0200_7057;
  localparam logic [31:0] VOP   = 32'h0000_0057;
  localparam logic [31:0] ADD   = 32'h0000_0033;

  cvxif_vec_issue_queue_if #(.XLEN(32), .NUM_RS(2), .ID_W(3), .DEPTH(4), .MAX_OUT(8)) bus_a ();
  cvxif_vec_issue_queue_if #(.XLEN(32), .NUM_RS(2), .ID_W(3), .DEPTH(4), .MAX_OUT(4)) bus_b ();

  cvxif_vec_issue_queue #(.XLEN(32), .NUM_RS(2), .ID_W(3), .DEPTH(4), .MAX_OUT(8)) dut_a (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_a)
  );

  cvxif_vec_issue_queue #(.XLEN(32), .NUM_RS(2), .ID_W(3), .DEPTH(4), .MAX_OUT(4)) dut_b (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;

    bus_a.issue_valid_i = 1'b0;  bus_b.issue_valid_i = 1'b0;
    bus_a.issue_instr_i = '0;    bus_b.issue_instr_i = '0;
    bus_a.issue_id_i = '0;       bus_b.issue_id_i = '0;
    bus_a.issue_rs_i = '0;       bus_b.issue_rs_i = '0;
    bus_a.issue_rs_valid_i = 2'b11; bus_b.issue_rs_valid_i = 2'b11;
    bus_a.flush_i = 1'b0;        bus_b.flush_i = 1'b0;
    bus_a.vec_ready_i = 1'b0;    bus_b.vec_ready_i = 1'b1;
    bus_a.vec_done_i = 1'b0;     bus_b.vec_done_i = 1'b0;
    bus_a.vec_done_id_i = '0;    bus_b.vec_done_id_i = '0;
    bus_a.vec_done_we_i = 1'b0;  bus_b.vec_done_we_i = 1'b0;
    bus_a.vec_done_data_i = '0;  bus_b.vec_done_data_i = '0;

    // reset state
    #3;
    chk("rst_vec_valid", 64'(bus_a.vec_valid_o), 64'd0);
    chk("rst_occ",       64'(bus_a.occupancy_o), 64'd0);
    chk("rst_out",       64'(bus_a.outstanding_o), 64'd0);
    chk("rst_res_valid", 64'(bus_a.result_valid_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // vset issue, accepted with writeback, visible next cycle
    bus_a.issue_instr_i = VSET;
    bus_a.issue_id_i    = 3'd3;
    bus_a.issue_rs_i    = {32'h0, 32'h0000_00A5};
    bus_a.issue_valid_i = 1'b1;
    #1;
    chk("vset_ready",  64'(bus_a.issue_ready_o), 64'd1);
    chk("vset_accept", 64'(bus_a.issue_accept_o), 64'd1);
    chk("vset_wb",     64'(bus_a.issue_writeback_o), 64'd1);
    tick();
    bus_a.issue_valid_i = 1'b0;
    #1;
    chk("vset_vec_valid", 64'(bus_a.vec_valid_o), 64'd1);
    chk("vset_vec_id",    64'(bus_a.vec_id_o), 64'd3);
    chk("vset_vec_rs0",   64'(bus_a.vec_rs_o[31:0]), 64'h0000_00A5);
    chk("vset_vec_instr", 64'(bus_a.vec_instr_o), 64'h0200_7057);
    chk("vset_out",       64'(bus_a.outstanding_o), 64'd1);
    chk("vset_occ",       64'(bus_a.occupancy_o), 64'd1);
    bus_a.vec_ready_i = 1'b1;
    tick();
    bus_a.vec_ready_i = 1'b0;
    #1;
    chk("drain_vec_valid", 64'(bus_a.vec_valid_o), 64'd0);
    chk("drain_out",       64'(bus_a.outstanding_o), 64'd1);
    bus_a.vec_done_i = 1'b1;
    bus_a.vec_done_id_i = 3'd3;
    bus_a.vec_done_we_i = 1'b1;
    bus_a.vec_done_data_i = 32'h55;
    tick();
    bus_a.vec_done_i = 1'b0;
    #1;
    chk("res1_valid", 64'(bus_a.result_valid_o), 64'd1);
    chk("res1_id",    64'(bus_a.result_id_o), 64'd3);
    chk("res1_we",    64'(bus_a.result_we_o), 64'd1);
    chk("res1_data",  64'(bus_a.result_data_o), 64'h55);
    chk("res1_out",   64'(bus_a.outstanding_o), 64'd0);
    tick();
    chk("res1_valid_drop", 64'(bus_a.result_valid_o), 64'd0);

    // non-vector instruction declined, no state change; flush blocks ready
    bus_a.issue_instr_i = ADD;
    bus_a.issue_valid_i = 1'b1;
    #1;
    chk("add_ready",  64'(bus_a.issue_ready_o), 64'd1);
    chk("add_accept", 64'(bus_a.issue_accept_o), 64'd0);
    chk("add_wb",     64'(bus_a.issue_writeback_o), 64'd0);
    bus_a.flush_i = 1'b1;
    #1;
    chk("add_flush_ready", 64'(bus_a.issue_ready_o), 64'd0);
    bus_a.flush_i = 1'b0;
    tick();
    bus_a.issue_valid_i = 1'b0;
    #1;
    chk("add_occ",       64'(bus_a.occupancy_o), 64'd0);
    chk("add_vec_valid", 64'(bus_a.vec_valid_o), 64'd0);
    chk("add_out",       64'(bus_a.outstanding_o), 64'd0);

    // fill FIFO with ids 0..3 while the vector unit stalls
    bus_a.issue_instr_i = VOP;
    for (int i = 0; i < 4; i++) begin
      bus_a.issue_id_i    = 3'(i);
      bus_a.issue_rs_i    = {32'h0, 32'(32'h100 + i)};
      bus_a.issue_valid_i = 1'b1;
      #1;
      chk("fill_ready",  64'(bus_a.issue_ready_o), 64'd1);
      chk("fill_accept", 64'(bus_a.issue_accept_o), 64'd1);
      chk("fill_wb",     64'(bus_a.issue_writeback_o), 64'd0);
      tick();
    end
    bus_a.issue_id_i = 3'd4;
    bus_a.issue_rs_i = {32'h0, 32'h104};
    #1;
    chk("full_ready",  64'(bus_a.issue_ready_o), 64'd0);
    chk("full_occ",    64'(bus_a.occupancy_o), 64'd4);
    chk("full_out",    64'(bus_a.outstanding_o), 64'd4);
    chk("full_head",   64'(bus_a.vec_id_o), 64'd0);
    bus_a.vec_ready_i = 1'b1;
    #1;
    chk("full_pop_ready", 64'(bus_a.issue_ready_o), 64'd0);
    tick();
    bus_a.vec_ready_i = 1'b0;
    #1;
    chk("after_pop_occ",   64'(bus_a.occupancy_o), 64'd3);
    chk("after_pop_ready", 64'(bus_a.issue_ready_o), 64'd1);
    chk("after_pop_head",  64'(bus_a.vec_id_o), 64'd1);
    chk("after_pop_out",   64'(bus_a.outstanding_o), 64'd4);
    tick();
    bus_a.issue_valid_i = 1'b0;
    #1;
    chk("refill_occ", 64'(bus_a.occupancy_o), 64'd4);
    chk("refill_out", 64'(bus_a.outstanding_o), 64'd5);
    bus_a.vec_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", 64'(bus_a.vec_valid_o), 64'd1);
      chk("drain_id",    64'(bus_a.vec_id_o), 64'(i));
      chk("drain_rs0",   64'(bus_a.vec_rs_o[31:0]), 64'(32'h100 + i));
      tick();
    end
    bus_a.vec_ready_i = 1'b0;
    chk("drained_valid", 64'(bus_a.vec_valid_o), 64'd0);
    chk("drained_occ",   64'(bus_a.occupancy_o), 64'd0);
    chk("drained_out",   64'(bus_a.outstanding_o), 64'd5);
    for (int i = 0; i < 5; i++) begin
      bus_a.vec_done_i      = 1'b1;
      bus_a.vec_done_id_i   = 3'(i);
      bus_a.vec_done_we_i   = 1'b0;
      bus_a.vec_done_data_i = 32'(i);
      tick();
      chk("cmpl_valid", 64'(bus_a.result_valid_o), 64'd1);
      chk("cmpl_id",    64'(bus_a.result_id_o), 64'(i));
    end
    bus_a.vec_done_i = 1'b0;
    chk("cmpl_out", 64'(bus_a.outstanding_o), 64'd0);

    // flush with 3 queued: head dispatches, rest killed
    for (int i = 0; i < 3; i++) begin
      bus_a.issue_id_i    = 3'(i);
      bus_a.issue_valid_i = 1'b1;
      tick();
    end
    bus_a.issue_valid_i = 1'b0;
    #1;
    chk("preflush_occ", 64'(bus_a.occupancy_o), 64'd3);
    chk("preflush_out", 64'(bus_a.outstanding_o), 64'd3);
    bus_a.flush_i       = 1'b1;
    bus_a.vec_ready_i   = 1'b1;
    bus_a.issue_id_i    = 3'd5;
    bus_a.issue_valid_i = 1'b1;
    #1;
    chk("flush_ready", 64'(bus_a.issue_ready_o), 64'd0);
    chk("flush_head",  64'(bus_a.vec_id_o), 64'd0);
    chk("flush_valid", 64'(bus_a.vec_valid_o), 64'd1);
    tick();
    bus_a.flush_i       = 1'b0;
    bus_a.vec_ready_i   = 1'b0;
    bus_a.issue_valid_i = 1'b0;
    #1;
    chk("postflush_occ",   64'(bus_a.occupancy_o), 64'd0);
    chk("postflush_valid", 64'(bus_a.vec_valid_o), 64'd0);
    chk("postflush_out",   64'(bus_a.outstanding_o), 64'd1);
    bus_a.vec_done_i      = 1'b1;
    bus_a.vec_done_id_i   = 3'd0;
    bus_a.vec_done_we_i   = 1'b1;
    bus_a.vec_done_data_i = 32'h10;
    tick();
    bus_a.vec_done_i = 1'b0;
    chk("flush_res_valid", 64'(bus_a.result_valid_o), 64'd1);
    chk("flush_res_id",    64'(bus_a.result_id_o), 64'd0);
    chk("flush_res_we",    64'(bus_a.result_we_o), 64'd1);
    chk("flush_res_data",  64'(bus_a.result_data_o), 64'h10);
    chk("flush_res_out",   64'(bus_a.outstanding_o), 64'd0);
    bus_a.issue_id_i    = 3'd6;
    bus_a.issue_valid_i = 1'b1;
    tick();
    bus_a.issue_valid_i = 1'b0;
    #1;
    chk("reuse_valid", 64'(bus_a.vec_valid_o), 64'd1);
    chk("reuse_id",    64'(bus_a.vec_id_o), 64'd6);
    chk("reuse_occ",   64'(bus_a.occupancy_o), 64'd1);

    // outstanding limit of 4 with the vector unit always ready
    bus_b.issue_instr_i = VOP;
    for (int i = 0; i < 4; i++) begin
      bus_b.issue_id_i    = 3'(i);
      bus_b.issue_valid_i = 1'b1;
      #1;
      chk("lim_ready", 64'(bus_b.issue_ready_o), 64'd1);
      tick();
    end
    bus_b.issue_id_i = 3'd4;
    #1;
    chk("lim_stall_ready", 64'(bus_b.issue_ready_o), 64'd0);
    chk("lim_stall_out",   64'(bus_b.outstanding_o), 64'd4);
    tick();
    chk("lim_hold_ready", 64'(bus_b.issue_ready_o), 64'd0);
    chk("lim_hold_out",   64'(bus_b.outstanding_o), 64'd4);
    bus_b.vec_done_i    = 1'b1;
    bus_b.vec_done_id_i = 3'd0;
    #1;
    chk("lim_done_ready", 64'(bus_b.issue_ready_o), 64'd0);
    tick();
    bus_b.vec_done_i = 1'b0;
    #1;
    chk("lim_after_done_out",   64'(bus_b.outstanding_o), 64'd3);
    chk("lim_after_done_ready", 64'(bus_b.issue_ready_o), 64'd1);
    chk("lim_after_done_res",   64'(bus_b.result_valid_o), 64'd1);
    tick();
    bus_b.issue_valid_i = 1'b0;
    #1;
    chk("lim_refill_out", 64'(bus_b.outstanding_o), 64'd4);
    chk("lim_refill_id",  64'(bus_b.vec_id_o), 64'd4);

    // asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("mrst_b_vec_valid", 64'(bus_b.vec_valid_o), 64'd0);
    chk("mrst_b_vec_id",    64'(bus_b.vec_id_o), 64'd0);
    chk("mrst_b_vec_instr", 64'(bus_b.vec_instr_o), 64'd0);
    chk("mrst_b_occ",       64'(bus_b.occupancy_o), 64'd0);
    chk("mrst_b_out",       64'(bus_b.outstanding_o), 64'd0);
    chk("mrst_b_res_valid", 64'(bus_b.result_valid_o), 64'd0);
    chk("mrst_b_ready",     64'(bus_b.issue_ready_o), 64'd0);
    chk("mrst_a_vec_valid", 64'(bus_a.vec_valid_o), 64'd0);
    chk("mrst_a_vec_rs",    64'(bus_a.vec_rs_o), 64'd0);
    chk("mrst_a_result",    64'(bus_a.result_data_o), 64'd0);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_out", 64'(bus_b.outstanding_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
